// File: rtl/md_h2k_unpacker_if.sv
// Host-to-kernel stream bundle: 512-bit AXIS beats in, 128-bit particle records out.
// master = beat producer / record consumer; slave = the unpacker.
interface md_h2k_unpacker_if #(
    parameter int AXIS_TDATA_WIDTH      = 512,
    parameter int STREAMING_TDEST_WIDTH = 16
);
    logic [AXIS_TDATA_WIDTH-1:0]      S_AXIS_h2k_tdata;
    logic [AXIS_TDATA_WIDTH/8-1:0]    S_AXIS_h2k_tkeep;
    logic                             S_AXIS_h2k_tvalid;
    logic                             S_AXIS_h2k_tlast;
    logic [STREAMING_TDEST_WIDTH-1:0] S_AXIS_h2k_tdest;
    logic                             S_AXIS_h2k_tready;

    logic                             p_valid;
    logic                             p_ready;
    logic [95:0]                      p_pos;
    logic [31:0]                      p_id;
    logic [STREAMING_TDEST_WIDTH-1:0] p_dest;
    logic                             p_last;

    modport master (
        output S_AXIS_h2k_tdata, S_AXIS_h2k_tkeep, S_AXIS_h2k_tvalid,
               S_AXIS_h2k_tlast, S_AXIS_h2k_tdest, p_ready,
        input  S_AXIS_h2k_tready, p_valid, p_pos, p_id, p_dest, p_last
    );

    modport slave (
        input  S_AXIS_h2k_tdata, S_AXIS_h2k_tkeep, S_AXIS_h2k_tvalid,
               S_AXIS_h2k_tlast, S_AXIS_h2k_tdest, p_ready,
        output S_AXIS_h2k_tready, p_valid, p_pos, p_id, p_dest, p_last
    );
endinterface

// File: rtl/md_h2k_unpacker.sv
// Splits each host-to-kernel beat into fully-kept 128-bit particle records, one per cycle,
// skipping empty slots without bubbles and tracking packet ends, record count and keep errors.
module md_h2k_unpacker #(
    parameter int AXIS_TDATA_WIDTH      = 512,
    parameter int SLOT_WIDTH            = 128,
    parameter int STREAMING_TDEST_WIDTH = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    md_h2k_unpacker_if.slave    h2k,
    input  logic                clear,
    output logic                pkt_done,
    output logic [31:0]         particle_count,
    output logic                keep_err
);
    localparam int NSLOT      = AXIS_TDATA_WIDTH / SLOT_WIDTH;
    localparam int SLOT_BYTES = SLOT_WIDTH / 8;

    typedef enum logic {EMPTY, DRAIN} state_e;

    state_e                           state_q, state_d;
    logic [AXIS_TDATA_WIDTH-1:0]      beat_q, beat_d;
    logic [NSLOT-1:0]                 mask_q, mask_d;
    logic                             last_q, last_d;
    logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;
    logic                             pkt_done_q, pkt_done_d;
    logic [31:0]                      count_q, count_d;
    logic                             keep_err_q, keep_err_d;

    logic [NSLOT-1:0]      slot_ok, slot_part, sel_oh;
    logic [SLOT_WIDTH-1:0] rec;
    logic                  one_left, p_valid, p_last, take, tready, accept;

    // Slot qualification of the incoming beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        slot_ok   = '0;
        slot_part = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_ok[i]   = &h2k.S_AXIS_h2k_tkeep[i*SLOT_BYTES +: SLOT_BYTES];
            slot_part[i] = (|h2k.S_AXIS_h2k_tkeep[i*SLOT_BYTES +: SLOT_BYTES]) && !slot_ok[i];
        end
    end

    // Lowest pending slot drives the record outputs; an empty mask selects nothing (all zero).
    always_comb begin
        sel_oh = mask_q & (~mask_q + NSLOT'(1));
        rec    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (sel_oh[i]) rec = rec | beat_q[i*SLOT_WIDTH +: SLOT_WIDTH];
        end
    end

    assign one_left = (mask_q != '0) && ((mask_q & (mask_q - NSLOT'(1))) == '0);
    assign p_valid  = (state_q == DRAIN);
    assign p_last   = last_q && one_left;
    assign take     = p_valid && h2k.p_ready;
    // Refill in the same cycle the final record leaves so back-to-back beats see no idle cycle.
    assign tready   = !ap_rst && ((state_q == EMPTY) || (take && one_left));
    assign accept   = h2k.S_AXIS_h2k_tvalid && tready;

    always_comb begin
        beat_d     = beat_q;
        mask_d     = mask_q;
        last_d     = last_q;
        dest_d     = dest_q;
        keep_err_d = keep_err_q;
        if (take) mask_d = mask_q & ~sel_oh;
        if (accept) begin
            beat_d = h2k.S_AXIS_h2k_tdata;
            mask_d = slot_ok;
            last_d = h2k.S_AXIS_h2k_tlast;
            dest_d = h2k.S_AXIS_h2k_tdest;
            if (slot_part != '0) keep_err_d = 1'b1;
        end
        if (clear) keep_err_d = 1'b0;
        state_d    = (mask_d != '0) ? DRAIN : EMPTY;
        // A tlast beat with no valid slot still closes its packet.
        pkt_done_d = (take && p_last) ||
                     (accept && h2k.S_AXIS_h2k_tlast && (slot_ok == '0));
        count_d    = clear ? '0 : count_q + 32'(take);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= EMPTY;
            mask_q     <= '0;
            last_q     <= 1'b0;
            dest_q     <= '0;
            pkt_done_q <= 1'b0;
            count_q    <= '0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            dest_q     <= dest_d;
            pkt_done_q <= pkt_done_d;
            count_q    <= count_d;
            keep_err_q <= keep_err_d;
        end
    end

    // NOTE: the beat register is not reset; an empty mask already forces the record outputs to zero.
    always_ff @(posedge ap_clk) begin
        beat_q <= beat_d;
    end

    assign h2k.S_AXIS_h2k_tready = tready;
    assign h2k.p_valid           = p_valid;
    assign h2k.p_pos             = rec[95:0];
    assign h2k.p_id              = rec[127:96];
    assign h2k.p_dest            = p_valid ? dest_q : '0;
    assign h2k.p_last            = p_last;

    assign pkt_done       = pkt_done_q;
    assign particle_count = count_q;
    assign keep_err       = keep_err_q;
endmodule

// File: tb/tb_md_h2k_unpacker.sv
// Randomized self-checking bench for md_h2k_unpacker against a queue-based record model.
module tb_md_h2k_unpacker;
    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [15:0]  dest;
    } beat_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  dest;
        logic         last;
    } rec_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clear = 1'b0;
    logic        pkt_done;
    logic [31:0] particle_count;
    logic        keep_err;

    md_h2k_unpacker_if bus ();

    md_h2k_unpacker dut (
        .ap_clk        (clk),
        .ap_rst        (rst),
        .h2k           (bus),
        .clear         (clear),
        .pkt_done      (pkt_done),
        .particle_count(particle_count),
        .keep_err      (keep_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    beat_t tx_q[$];
    rec_t  exp_q[$];
    logic [31:0]  m_count;
    logic         m_kerr;
    logic         m_done;
    logic         stalled;
    logic [144:0] held;
    int ready_pct = 100;
    int valid_pct = 100;
    int clear_pct = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic beat_t make_beat(input logic [63:0] keep, input logic last);
        beat_t b;
        b.data = {rand128(), rand128(), rand128(), rand128()};
        b.keep = keep;
        b.last = last;
        b.dest = 16'($urandom());
        return b;
    endfunction

    function automatic logic [63:0] rand_keep();
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 5))
                0:       k[i*16 +: 16] = 16'h0000;
                1:       k[i*16 +: 16] = 16'($urandom());
                default: k[i*16 +: 16] = 16'hFFFF;
            endcase
        end
        return k;
    endfunction

    // One clock cycle: drive at the falling edge, check settled outputs, advance the model.
    task automatic step();
        logic         take, acc, exp_tready, exp_valid, done_n;
        logic [144:0] now;
        beat_t        b;
        rec_t         r;
        int           last_slot;

        bus.S_AXIS_h2k_tvalid = (tx_q.size() != 0) && ($urandom_range(1, 100) <= valid_pct);
        if (tx_q.size() != 0) begin
            bus.S_AXIS_h2k_tdata = tx_q[0].data;
            bus.S_AXIS_h2k_tkeep = tx_q[0].keep;
            bus.S_AXIS_h2k_tlast = tx_q[0].last;
            bus.S_AXIS_h2k_tdest = tx_q[0].dest;
        end
        bus.p_ready = ($urandom_range(1, 100) <= ready_pct);
        clear       = ($urandom_range(1, 100) <= clear_pct);
        #1;

        exp_valid  = (exp_q.size() != 0);
        exp_tready = (exp_q.size() == 0) || (bus.p_ready && exp_q.size() == 1);
        check("p_valid",  192'(bus.p_valid),           192'(exp_valid));
        check("tready",   192'(bus.S_AXIS_h2k_tready), 192'(exp_tready));
        check("pkt_done", 192'(pkt_done),              192'(m_done));
        check("count",    192'(particle_count),        192'(m_count));
        check("keep_err", 192'(keep_err),              192'(m_kerr));
        now = {bus.p_pos, bus.p_id, bus.p_dest, bus.p_last};
        if (exp_valid) begin
            check("record", 192'({bus.p_id, bus.p_pos}), 192'(exp_q[0].data));
            check("p_dest", 192'(bus.p_dest),            192'(exp_q[0].dest));
            check("p_last", 192'(bus.p_last),            192'(exp_q[0].last));
        end
        if (stalled) check("hold", 192'(now), 192'(held));

        take   = exp_valid && bus.p_ready;
        acc    = bus.S_AXIS_h2k_tvalid && exp_tready;
        done_n = 1'b0;
        if (take) begin
            done_n = exp_q[0].last;
            void'(exp_q.pop_front());
        end
        m_count = clear ? 32'd0 : m_count + 32'(take);
        if (clear) m_kerr = 1'b0;
        if (acc) begin
            b = tx_q.pop_front();
            last_slot = -1;
            for (int i = 0; i < 4; i++)
                if (b.keep[i*16 +: 16] == 16'hFFFF) last_slot = i;
            for (int i = 0; i < 4; i++) begin
                if (b.keep[i*16 +: 16] == 16'hFFFF) begin
                    r.data = b.data[i*128 +: 128];
                    r.dest = b.dest;
                    r.last = b.last && (i == last_slot);
                    exp_q.push_back(r);
                end else if (b.keep[i*16 +: 16] != 16'h0000 && !clear) begin
                    m_kerr = 1'b1;
                end
            end
            if (b.last && last_slot < 0) done_n = 1'b1;
        end

        @(posedge clk);
        m_done  = done_n;
        stalled = exp_valid && !take;
        held    = now;
        @(negedge clk);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0 || m_done) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("timeout", 192'(1), 192'(0));
        step();
        step();
    endtask

    initial begin
        bus.S_AXIS_h2k_tvalid = 1'b0;
        bus.S_AXIS_h2k_tdata  = '0;
        bus.S_AXIS_h2k_tkeep  = '0;
        bus.S_AXIS_h2k_tlast  = 1'b0;
        bus.S_AXIS_h2k_tdest  = '0;
        bus.p_ready           = 1'b0;
        m_count = '0;
        m_kerr  = 1'b0;
        m_done  = 1'b0;
        stalled = 1'b0;
        held    = '0;

        repeat (2) @(negedge clk);
        check("rst_tready",   192'(bus.S_AXIS_h2k_tready), 192'(0));
        check("rst_p_valid",  192'(bus.p_valid),           192'(0));
        check("rst_p_last",   192'(bus.p_last),            192'(0));
        check("rst_pkt_done", 192'(pkt_done),              192'(0));
        check("rst_count",    192'(particle_count),        192'(0));
        check("rst_keep_err", 192'(keep_err),              192'(0));
        check("rst_outputs",  192'({bus.p_pos, bus.p_id, bus.p_dest}), 192'(0));
        rst = 1'b0;

        // Single full beat closing a packet.
        tx_q.push_back(make_beat('1, 1'b1));
        run(50);
        check("t1_count", 192'(particle_count), 192'(4));

        // Three back-to-back full beats.
        for (int i = 0; i < 3; i++) tx_q.push_back(make_beat('1, i == 2));
        run(50);

        // Empty slots skipped; partial slot flags keep_err until clear.
        tx_q.push_back(make_beat(64'h0000_FFFF_0000_FFFF, 1'b1));
        run(50);
        tx_q.push_back(make_beat(64'hFFFF_FFFF_00FF_FFFF, 1'b1));
        run(50);
        check("t3_keep_err", 192'(keep_err), 192'(1));
        clear_pct = 100;
        step();
        clear_pct = 0;
        step();
        check("t3_cleared", 192'(keep_err), 192'(0));

        // Random downstream stalls across a 2-beat packet.
        ready_pct = 50;
        tx_q.push_back(make_beat('1, 1'b0));
        tx_q.push_back(make_beat('1, 1'b1));
        run(200);
        ready_pct = 100;

        // All-empty beat still closes its packet.
        tx_q.push_back(make_beat('0, 1'b1));
        run(50);

        // Reset in the middle of a drain.
        tx_q.push_back(make_beat('1, 1'b1));
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_p_valid", 192'(bus.p_valid),           192'(0));
        check("midrst_count",   192'(particle_count),        192'(0));
        check("midrst_tready",  192'(bus.S_AXIS_h2k_tready), 192'(0));
        exp_q.delete();
        tx_q.delete();
        m_count = '0;
        m_kerr  = 1'b0;
        m_done  = 1'b0;
        stalled = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tx_q.push_back(make_beat('1, 1'b1));
        run(50);
        check("t6_count", 192'(particle_count), 192'(4));

        // Randomized traffic with stalls, gaps, clears and mixed keep.
        ready_pct = 70;
        valid_pct = 80;
        clear_pct = 3;
        for (int i = 0; i < 300; i++) tx_q.push_back(make_beat(rand_keep(), $urandom_range(0, 2) == 0));
        run(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
